// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: shifts a captured pattern out MSB-first with optional repeats.
// Optional feature macro PARITY_TX_EN adds an even-parity bit after every repetition.
module serial_pattern_tx #(
  parameter  int W  = 8,
  parameter  int CW = 4,
  localparam int LW = $clog2(W) + 1
) (
  input  logic          CLK,
  input  logic          RESET_N,
  input  logic          START,
  input  logic [W-1:0]  DATA,
  input  logic [LW-1:0] LEN,
  input  logic [CW-1:0] REPS,
  output logic          X,
  output logic          VALID,
  output logic          BUSY,
  output logic          DONE,
  output logic [2:0]    S
);

  localparam int IW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b000,
    ST_SHIFT = 3'b010,
`ifdef PARITY_TX_EN
    ST_PAR   = 3'b100,
`endif
    ST_GAP   = 3'b011,
    ST_FIN   = 3'b101
  } state_t;

  state_t        state;
  logic [W-1:0]  pat;
  logic [IW-1:0] last_idx;
  logic [IW-1:0] bit_idx;
  logic [CW-1:0] reps_left;

  logic [LW-1:0] len_c;
  logic [CW-1:0] reps_c;
  logic [W-1:0]  mask_c;
  logic [IW-1:0] last_c;
  logic          rep_end;
  logic          more_reps;

  // NOTE: every signal written in always_comb gets a default first so no latch can be inferred.
  always_comb begin
    len_c     = (LEN > LW'(W)) ? LW'(W) : LEN;
    reps_c    = (REPS == '0) ? CW'(1) : REPS;
    mask_c    = ~({W{1'b1}} << len_c);
    last_c    = IW'(len_c - LW'(1));
    more_reps = (reps_left > CW'(1));
`ifdef PARITY_TX_EN
    rep_end   = (state == ST_PAR);
`else
    rep_end   = (state == ST_SHIFT) && (bit_idx == '0);
`endif
  end

  assign S = state;

  // Pattern is stored masked to LEN bits so parity is simply the XOR of the register.
  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= ST_IDLE;
      pat       <= '0;
      last_idx  <= '0;
      bit_idx   <= '0;
      reps_left <= '0;
      X         <= 1'b0;
      VALID     <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
    end else if (rep_end) begin
      reps_left <= reps_left - CW'(1);
      X         <= 1'b0;
      VALID     <= 1'b0;
      if (more_reps) begin
        state <= ST_GAP;
      end else begin
        state <= ST_FIN;
        DONE  <= 1'b1;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (START) begin
            pat       <= DATA & mask_c;
            last_idx  <= last_c;
            reps_left <= reps_c;
            BUSY      <= 1'b1;
            if (len_c == '0) begin
              state <= ST_FIN;
              DONE  <= 1'b1;
            end else begin
              state   <= ST_SHIFT;
              X       <= DATA[last_c];
              VALID   <= 1'b1;
              bit_idx <= last_c;
            end
          end
        end
        ST_SHIFT: begin
`ifdef PARITY_TX_EN
          if (bit_idx == '0) begin
            state <= ST_PAR;
            X     <= ^pat;
          end else begin
            bit_idx <= bit_idx - IW'(1);
            X       <= pat[bit_idx - IW'(1)];
          end
`else
          bit_idx <= bit_idx - IW'(1);
          X       <= pat[bit_idx - IW'(1)];
`endif
        end
        ST_GAP: begin
          state   <= ST_SHIFT;
          X       <= pat[last_idx];
          VALID   <= 1'b1;
          bit_idx <= last_idx;
        end
        ST_FIN: begin
          state <= ST_IDLE;
          DONE  <= 1'b0;
          BUSY  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          X     <= 1'b0;
          VALID <= 1'b0;
          BUSY  <= 1'b0;
          DONE  <= 1'b0;
        end
      endcase
    end
  end

endmodule
